bus_initiator: RTL

- Single-outstanding initiator for the SoC's simple valid/ready peripheral bus; the counterpart of register-mapped responders such as the GPIO block.
- Accepts one command (read or write) on a ready/valid command port and drives addr/wdata/wstrb/valid until the responder answers with ready.
- Returns read data and an error flag on a ready/valid response port.
- Bounds every access with a timeout; used by debug/DMA-style agents that need bus access.

---
 rtl/soc_bus_pkg.sv | 16 +
 rtl/bus_initiator.sv | 131 +++++++++++++
 2 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the simple valid/ready peripheral bus:
// bus widths and the initiator state encoding.
package soc_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Initiator FSM states; encodings are fixed so they read the same in waveforms.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: takes one read/write command, drives the
// peripheral bus until the responder answers (or a timeout expires), then
// returns the read data and an error flag on the response port.
module bus_initiator
    import soc_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              valid,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] rdata
);

    // Last counter value before the access is abandoned.
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    bus_state_t        state_reg, state_next;
    logic [CW-1:0]     counter_reg, counter_next;
    logic              valid_reg, valid_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0] wstrb_reg, wstrb_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;

    // Next-state and next-output logic; ready is only looked at in REQ so the
    // responder's trailing ready cycle (which lands in RSP) is harmless.
    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        valid_next     = valid_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    addr_next    = cmd_addr;
                    wdata_next   = cmd_wdata;
                    // A zero strobe marks a read on the bus.
                    wstrb_next   = cmd_we ? cmd_wstrb : '0;
                    valid_next   = 1'b1;
                    counter_next = '0;
                    state_next   = REQ;
                end
            end
            REQ: begin
                // Completion takes priority over a timeout on the same edge.
                if (ready) begin
                    valid_next     = 1'b0;
                    rsp_rdata_next = (wstrb_reg == '0) ? rdata : '0;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end else if (counter_reg == LAST_CNT) begin
                    valid_next     = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end else begin
                    counter_next = counter_reg + CW'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            valid_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            valid_reg     <= valid_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign valid     = valid_reg;
    assign addr      = addr_reg;
    assign wdata     = wdata_reg;
    assign wstrb     = wstrb_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
